multiples_detect: RTL and testbench

- Registered divisibility indicator for a 5-bit unsigned operand `num`.
- Each of five LED outputs shows whether the current `num` is an exact multiple of one fixed divisor (default divisors 2, 3, 4, 5, 6).
- Sits between a switch/operand source and board LEDs.
- Sweeping `num` from 0 to 31 must give a stable, glitch-free LED pattern per value.

---
 rtl/multiples_detect.sv | 106 ++++++++++
 tb/tb_multiples_detect.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/multiples_detect.sv
// ---------------------------------------------------------------------------
// multiples_detect
//
// Registered divisibility indicator. Each LED output shows whether the
// operand `num` is an exact multiple of one fixed divisor. The value sampled
// on a rising clk edge appears on the LEDs right after that edge. Every LED
// is driven straight from a flip-flop, so there is no combinational path
// from `num` to the LEDs and the display cannot glitch.
//
// Parameters:
//   WIDTH      bit width of num (2..8)
//   DIV1..DIV5 divisors for LED1..LED5. A divisor of 0 is illegal. That LED
//              is then held at 0 and a warning is issued at elaboration.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset; clears all LEDs at once
//   num        unsigned operand, sampled every rising clk edge
//   LED1..LED5 1 when the last sampled num is a multiple of DIV1..DIV5
//
// Optional build macro:
//   MULTIPLES_ZERO_BLANK_EN  when defined, num == 0 blanks all LEDs
//                            instead of lighting them all.
// ---------------------------------------------------------------------------
module multiples_detect #(
    parameter int          WIDTH = 5,
    parameter int unsigned DIV1  = 2,
    parameter int unsigned DIV2  = 3,
    parameter int unsigned DIV3  = 4,
    parameter int unsigned DIV4  = 5,
    parameter int unsigned DIV5  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] num,
    output logic             LED1,
    output logic             LED2,
    output logic             LED3,
    output logic             LED4,
    output logic             LED5
);

    localparam int unsigned DIVS [5] = '{DIV1, DIV2, DIV3, DIV4, DIV5};

    // Flag illegal zero divisors while the design is elaborated.
    for (genvar i = 0; i < 5; i++) begin : g_div_check
        if (DIVS[i] == 0) begin : g_zero_div
            $warning("multiples_detect: divisor for LED%0d is 0; LED held at 0", i + 1);
        end
    end

    // Generic remainder by restoring long division. At step k the divisor
    // shifted left by k is subtracted if it fits. After WIDTH steps only the
    // remainder is left. The working width leaves room for any 32-bit
    // divisor shifted by up to WIDTH-1 places.
    function automatic logic is_multiple(input logic [WIDTH-1:0] v,
                                         input int unsigned      d);
        logic [WIDTH+31:0] r;
        logic [WIDTH+31:0] dd;
        logic [WIDTH+31:0] sub;
        r  = '0;
        r[WIDTH-1:0] = v;
        dd = {{WIDTH{1'b0}}, d};
        if (d == 0) begin
            return 1'b0;
        end
        for (int k = WIDTH - 1; k >= 0; k--) begin
            sub = dd << k;
            if (r >= sub) begin
                r = r - sub;
            end
        end
        return (r == '0);
    endfunction

    logic [4:0] led_next;
    logic [4:0] led_q;

    always_comb begin
        led_next = '0;
        for (int i = 0; i < 5; i++) begin
            led_next[i] = is_multiple(num, DIVS[i]);
        end
`ifdef MULTIPLES_ZERO_BLANK_EN
        // A blank display for zero instead of "multiple of everything".
        if (num == '0) begin
            led_next = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_next;
        end
    end

    assign LED1 = led_q[0];
    assign LED2 = led_q[1];
    assign LED3 = led_q[2];
    assign LED4 = led_q[3];
    assign LED5 = led_q[4];

endmodule

// File: tb/tb_multiples_detect.sv
// ---------------------------------------------------------------------------
// tb_multiples_detect
//
// Bench for multiples_detect. The main instance uses the default divisors
// (2,3,4,5,6). A second instance overrides DIV4 = 7 and shares the same
// clock, reset and operand. LED vectors are packed as {LED5..LED1}.
// ---------------------------------------------------------------------------
module tb_multiples_detect;

    localparam int W = 5;

    // ---------------- clock / reset ----------------
    logic         clk;
    logic         rst_n;
    logic [W-1:0] num;

    logic l1, l2, l3, l4, l5;
    logic m1, m2, m3, m4, m5;
    logic [4:0] leds;
    logic [4:0] leds7;

    assign leds  = {l5, l4, l3, l2, l1};
    assign leds7 = {m5, m4, m3, m2, m1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multiples_detect #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .num(num),
        .LED1(l1), .LED2(l2), .LED3(l3), .LED4(l4), .LED5(l5)
    );

    multiples_detect #(.WIDTH(W), .DIV4(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .num(num),
        .LED1(m1), .LED2(m2), .LED3(m3), .LED4(m4), .LED5(m5)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp7_q[$];

    // Reference model: plain modulo arithmetic on the divisor list.
    function automatic logic [4:0] model(input int n, input int d4);
        int divs[5];
        logic [4:0] r;
        divs = '{2, 3, 4, d4, 6};
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[i] = ((n % divs[i]) == 0);
        end
`ifdef MULTIPLES_ZERO_BLANK_EN
        if (n == 0) r = '0;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, then return 1 ns after the next rising edge.
    task automatic apply(input logic [W-1:0] n);
        @(negedge clk);
        num = n;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [W-1:0] n;
        logic [4:0]   exp;
        string        name;
    } vec_t;

    vec_t vecs[5];

    // Watchdog: the run is cycle-bounded, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c1;
        int c5;
        logic [4:0] prev;
        logic [W-1:0] r;

        // Hand-derived expectations, {LED5..LED1}.
        vecs[0] = '{5'd12, 5'b10111, "vec_12"};
        vecs[1] = '{5'd30, 5'b11011, "vec_30"};
        vecs[2] = '{5'd20, 5'b01101, "vec_20"};
`ifdef MULTIPLES_ZERO_BLANK_EN
        vecs[3] = '{5'd0,  5'b00000, "vec_0"};
`else
        vecs[3] = '{5'd0,  5'b11111, "vec_0"};
`endif
        vecs[4] = '{5'd31, 5'b00000, "vec_31"};

        // ---- reset held with the clock running ----
        rst_n = 1'b0;
        num   = 5'd12;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", leds, 5'b00000);
        check("reset_hold_div7", leds7, 5'b00000);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_12", leds, 5'b10111);

        // ---- table vectors ----
        foreach (vecs[i]) begin
            apply(vecs[i].n);
            check(vecs[i].name, leds, vecs[i].exp);
        end

        // ---- sweep 0..31 with latency and count checks ----
        c1   = 0;
        c5   = 0;
        prev = leds;
        for (int v = 0; v < 32; v++) begin
            @(negedge clk);
            num = W'(v);
            #1;
            // New operand must not reach the LEDs before the edge.
            check("sweep_hold", leds, prev);
            @(posedge clk);
            #1;
            check("sweep", leds, model(v, 5));
            check("sweep_div7", leds7, model(v, 7));
            c1  += int'(l1);
            c5  += int'(l5);
            prev = leds;
        end
`ifdef MULTIPLES_ZERO_BLANK_EN
        check_int("count_led1", c1, 15);
        check_int("count_led5", c5, 5);
`else
        check_int("count_led1", c1, 16);
        check_int("count_led5", c5, 6);
`endif

        // ---- asynchronous reset between edges ----
        apply(5'd18);
        check("pre_reset_18", leds, 5'b10011);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", leds, 5'b00000);
        check("async_clear_div7", leds7, 5'b00000);
        #1;
        rst_n = 1'b1;
        #1;
        check("released_no_edge", leds, 5'b00000);
        @(posedge clk);
        #1;
        check("restore_18", leds, 5'b10011);

        // ---- DIV4 = 7 override ----
        apply(5'd21);
        check("div7_21", {4'b0, m4}, 5'd1);
        apply(5'd20);
        check("div7_20", {4'b0, m4}, 5'd0);

        // ---- wrap 31 -> 0 ----
        apply(5'd31);
        check("wrap_31", leds, model(31, 5));
        apply(5'd0);
        check("wrap_0", leds, model(0, 5));

        // ---- randomized stimulus against the model ----
        for (int i = 0; i < 200; i++) begin
            r = W'($urandom_range(0, 31));
            exp_q.push_back(model(int'(r), 5));
            exp7_q.push_back(model(int'(r), 7));
            apply(r);
            check("rand", leds, exp_q.pop_front());
            check("rand_div7", leds7, exp7_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
